// File: rtl/ctrl_mc_pkg.sv
// ctrl_mc_pkg: shared definitions for the multi-cycle control unit.
//   - FSM state encodings (visible on state_o for debug)
//   - trap cause codes
//   - datapath select encodings (immediate format, ALU function, writeback source)
//   - registered control-word struct produced by the decoder
//   - timeout counter width and the branch-condition helper
package ctrl_mc_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_BUS     = 2'd2,
    CAUSE_ECALL   = 2'd3
  } cause_e;

  // Instruction class decides the path taken after EXEC.
  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_LOAD   = 3'd1,
    CL_STORE  = 3'd2,
    CL_BRANCH = 3'd3,
    CL_JUMP   = 3'd4,
    CL_FENCE  = 3'd5
  } class_e;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // ALU functions
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Writeback sources
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Control word captured in DECODE and replayed through EXEC/MEM/WB.
  typedef struct packed {
    logic [2:0] imm_sel;
    logic       br_un;
    logic       a_sel;
    logic       b_sel;
    logic [3:0] alu_sel;
    logic       mem_rw;
    logic [1:0] wb_sel;
    logic [2:0] funct3;
    class_e     cls;
  } ctrlw_t;

  localparam int     CTRLW_W       = $bits(ctrlw_t);
  localparam ctrlw_t CTRLW_DEFAULT = '0;

  // Bus wait counter width (timeout range 1..255)
  localparam int TMO_W = 8;

  // ALU function from funct3; alt selects SUB/SRA.
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  // Branch condition from funct3 and the comparator flags.
  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = lt;
      3'b111:  br_taken = !lt;
      default: br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_mc_decode.sv
// ctrl_mc_decode: purely combinational RV32I decoder.
//   inst_i     instruction word
//   cw_o       control word (selects, funct3, instruction class)
//   illegal_o  unsupported opcode/funct combination (CSR when disabled)
//   ecall_o    ECALL or EBREAK
module ctrl_mc_decode
  import ctrl_mc_pkg::*;
#(
  parameter int ENABLE_CSR = 0
) (
  input  logic [31:0] inst_i,
  output ctrlw_t      cw_o,
  output logic        illegal_o,
  output logic        ecall_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  always_comb begin
    cw_o        = CTRLW_DEFAULT;
    cw_o.funct3 = f3;
    illegal_o   = 1'b0;
    ecall_o     = 1'b0;
    case (opcode)
      OPC_REG: begin
        cw_o.alu_sel = alu_fn(f3, f7[5]);
        // funct7=0100000 is only defined for SUB and SRA
        if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)))))
          illegal_o = 1'b1;
      end
      OPC_IMM: begin
        cw_o.imm_sel = IMM_I;
        cw_o.b_sel   = 1'b1;
        // ADDI with bit 30 set is still ADDI; only shifts look at funct7
        cw_o.alu_sel = alu_fn(f3, (f3 == 3'b101) && f7[5]);
        if (((f3 == 3'b001) && (f7 != 7'h00)) ||
            ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20)))
          illegal_o = 1'b1;
      end
      OPC_LOAD: begin
        cw_o.cls     = CL_LOAD;
        cw_o.imm_sel = IMM_I;
        cw_o.b_sel   = 1'b1;
        cw_o.wb_sel  = WB_MEM;
        if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111))
          illegal_o = 1'b1;
      end
      OPC_STORE: begin
        cw_o.cls     = CL_STORE;
        cw_o.imm_sel = IMM_S;
        cw_o.b_sel   = 1'b1;
        cw_o.mem_rw  = 1'b1;
        if (f3 > 3'b010)
          illegal_o = 1'b1;
      end
      OPC_BRANCH: begin
        cw_o.cls     = CL_BRANCH;
        cw_o.imm_sel = IMM_B;
        cw_o.a_sel   = 1'b1;
        cw_o.b_sel   = 1'b1;
        cw_o.br_un   = f3[1];
        if ((f3 == 3'b010) || (f3 == 3'b011))
          illegal_o = 1'b1;
      end
      OPC_LUI: begin
        cw_o.imm_sel = IMM_U;
        cw_o.b_sel   = 1'b1;
        cw_o.alu_sel = ALU_PASSB;
      end
      OPC_AUIPC: begin
        cw_o.imm_sel = IMM_U;
        cw_o.a_sel   = 1'b1;
        cw_o.b_sel   = 1'b1;
      end
      OPC_JAL: begin
        cw_o.cls     = CL_JUMP;
        cw_o.imm_sel = IMM_J;
        cw_o.a_sel   = 1'b1;
        cw_o.b_sel   = 1'b1;
        cw_o.wb_sel  = WB_PC4;
      end
      OPC_JALR: begin
        cw_o.cls     = CL_JUMP;
        cw_o.imm_sel = IMM_I;
        cw_o.b_sel   = 1'b1;
        cw_o.wb_sel  = WB_PC4;
        if (f3 != 3'b000)
          illegal_o = 1'b1;
      end
      OPC_FENCE: begin
        cw_o.cls = CL_FENCE;
        if (f3 > 3'b001)
          illegal_o = 1'b1;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          // ECALL (imm 0) / EBREAK (imm 1) with rs1 = rd = 0; MRET/WFI etc. unsupported
          if ((inst_i[19:7] == 13'd0) && (inst_i[31:21] == 11'd0))
            ecall_o = 1'b1;
          else
            illegal_o = 1'b1;
        end else if ((ENABLE_CSR != 0) && (f3 != 3'b100)) begin
          cw_o.imm_sel = IMM_I;
          cw_o.b_sel   = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB + TRAP).
//   clk, rst                synchronous active-high reset
//   inst_i                  IR contents, valid from DECODE onward
//   imem_req_o/imem_ack_i   instruction fetch handshake
//   dmem_req_o/dmem_ack_i   data access handshake
//   BrEq_i, BrLt_i          branch comparator flags
//   PCWEn_o, IRWEn_o        PC / IR write enables
//   PCSel_o ImmSel_o BrUn_o ASel_o BSel_o ALUSel_o MemRW_o RegWEn_o WBSel_o
//                           datapath selects
//   retire_o                one pulse per committed instruction
//   trap_o, trap_cause_o    trap status
//   state_o                 current FSM state
module ctrl_mc
  import ctrl_mc_pkg::*;
#(
  parameter int INST_W      = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TRAP_HALT   = 1,
  parameter int ENABLE_CSR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst_i,
  output logic              imem_req_o,
  input  logic              imem_ack_i,
  output logic              dmem_req_o,
  input  logic              dmem_ack_i,
  input  logic              BrEq_i,
  input  logic              BrLt_i,
  output logic              PCWEn_o,
  output logic              IRWEn_o,
  output logic              PCSel_o,
  output logic [2:0]        ImmSel_o,
  output logic              BrUn_o,
  output logic              ASel_o,
  output logic              BSel_o,
  output logic [3:0]        ALUSel_o,
  output logic              MemRW_o,
  output logic              RegWEn_o,
  output logic [1:0]        WBSel_o,
  output logic              retire_o,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o,
  output logic [2:0]        state_o
);

  // Last waiting cycle: an ack here still wins, otherwise the bus faults.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  ctrlw_t           cw_q, cw_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  cause_e           cause_q, cause_d;

  ctrlw_t dec_cw;
  logic   dec_illegal;
  logic   dec_ecall;
  logic   expired;
  logic   cw_active;
  logic   taken;

  ctrl_mc_decode #(
    .ENABLE_CSR(ENABLE_CSR)
  ) u_decode (
    .inst_i   (inst_i[31:0]),
    .cw_o     (dec_cw),
    .illegal_o(dec_illegal),
    .ecall_o  (dec_ecall)
  );

  assign expired = (cnt_q == TMO_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_DECODE: begin
        cw_d = dec_cw;
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_ecall) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ECALL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = '0;
        case (cw_q.cls)
          CL_BRANCH, CL_FENCE: state_d = ST_FETCH;
          CL_LOAD, CL_STORE:   state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack_i) begin
          state_d = (cw_q.cls == CL_STORE) ? ST_FETCH : ST_WB;
          cnt_d   = '0;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_TRAP: begin
        if (TRAP_HALT == 0) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      cw_q    <= CTRLW_DEFAULT;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Selects follow the captured control word only while an instruction is executing.
  assign cw_active = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
  assign taken     = br_taken(cw_q.funct3, BrEq_i, BrLt_i);

  assign ImmSel_o = cw_active ? cw_q.imm_sel : IMM_I;
  assign BrUn_o   = cw_active & cw_q.br_un;
  assign ASel_o   = cw_active & cw_q.a_sel;
  assign BSel_o   = cw_active & cw_q.b_sel;
  assign ALUSel_o = cw_active ? cw_q.alu_sel : ALU_ADD;
  assign MemRW_o  = cw_active & cw_q.mem_rw;
  assign WBSel_o  = cw_active ? cw_q.wb_sel : WB_ALU;

  assign imem_req_o   = (state_q == ST_FETCH);
  assign dmem_req_o   = (state_q == ST_MEM);
  assign IRWEn_o      = (state_q == ST_FETCH) && imem_ack_i;
  assign trap_o       = (state_q == ST_TRAP);
  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

  always_comb begin
    PCWEn_o  = 1'b0;
    PCSel_o  = 1'b0;
    RegWEn_o = 1'b0;
    retire_o = 1'b0;
    case (state_q)
      ST_EXEC: begin
        if (cw_q.cls == CL_BRANCH) begin
          PCSel_o  = taken;
          PCWEn_o  = 1'b1;
          retire_o = 1'b1;
        end else if (cw_q.cls == CL_FENCE) begin
          PCWEn_o  = 1'b1;
          retire_o = 1'b1;
        end
      end
      ST_MEM: begin
        if (dmem_ack_i && (cw_q.cls == CL_STORE)) begin
          PCWEn_o  = 1'b1;
          retire_o = 1'b1;
        end
      end
      ST_WB: begin
        RegWEn_o = 1'b1;
        PCWEn_o  = 1'b1;
        PCSel_o  = (cw_q.cls == CL_JUMP);
        retire_o = 1'b1;
      end
      ST_TRAP: begin
        // Non-halting trap skips the faulting instruction via PC+4
        PCWEn_o = (TRAP_HALT == 0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: randomized instruction stream against a transaction-level model.
// Main DUT: MEM_TIMEOUT=4, TRAP_HALT=0, ENABLE_CSR=0. Second DUT (TRAP_HALT=1,
// ENABLE_CSR=1) exercises the sticky trap and CSR path with literal expectations.
module tb_ctrl_mc;
  import ctrl_mc_pkg::*;

  localparam int TMO = 4;

  localparam logic [3:0] K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JMP = 4,
                         K_FEN = 5, K_ILL = 6, K_ECALL = 7;

  typedef struct packed {
    logic [3:0] cls;
    logic [2:0] imm;
    logic       brun;
    logic       asel;
    logic       bsel;
    logic [3:0] alu;
    logic       memrw;
    logic [1:0] wb;
    logic [2:0] f3;
  } info_t;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       dmem_req;
    logic       pcwen;
    logic       irwen;
    logic       pcsel;
    logic [2:0] immsel;
    logic       brun;
    logic       asel;
    logic       bsel;
    logic [3:0] alusel;
    logic       memrw;
    logic       regwen;
    logic [1:0] wbsel;
    logic       retire;
    logic       trap;
    logic [1:0] cause;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, breq = 1'b0, brlt = 1'b0;
  logic        o_imem_req, o_dmem_req, o_pcwen, o_irwen, o_pcsel, o_brun, o_asel, o_bsel;
  logic        o_memrw, o_regwen, o_retire, o_trap;
  logic [2:0]  o_immsel, o_state;
  logic [3:0]  o_alusel;
  logic [1:0]  o_wbsel, o_cause;

  // Halting DUT signals
  logic        h_rst = 1'b1;
  logic [31:0] h_inst = '0;
  logic        h_imem_ack = 1'b0, h_dmem_ack = 1'b0, h_zero = 1'b0;
  logic        h_imem_req, h_dmem_req, h_pcwen, h_irwen, h_pcsel, h_brun, h_asel, h_bsel;
  logic        h_memrw, h_regwen, h_retire, h_trap;
  logic [2:0]  h_immsel, h_state;
  logic [3:0]  h_alusel;
  logic [1:0]  h_wbsel, h_cause;

  ctrl_mc #(.INST_W(32), .MEM_TIMEOUT(TMO), .TRAP_HALT(0), .ENABLE_CSR(0)) u_dut (
    .clk(clk), .rst(rst), .inst_i(inst),
    .imem_req_o(o_imem_req), .imem_ack_i(imem_ack),
    .dmem_req_o(o_dmem_req), .dmem_ack_i(dmem_ack),
    .BrEq_i(breq), .BrLt_i(brlt),
    .PCWEn_o(o_pcwen), .IRWEn_o(o_irwen), .PCSel_o(o_pcsel), .ImmSel_o(o_immsel),
    .BrUn_o(o_brun), .ASel_o(o_asel), .BSel_o(o_bsel), .ALUSel_o(o_alusel),
    .MemRW_o(o_memrw), .RegWEn_o(o_regwen), .WBSel_o(o_wbsel),
    .retire_o(o_retire), .trap_o(o_trap), .trap_cause_o(o_cause), .state_o(o_state)
  );

  ctrl_mc #(.INST_W(32), .MEM_TIMEOUT(TMO), .TRAP_HALT(1), .ENABLE_CSR(1)) u_halt (
    .clk(clk), .rst(h_rst), .inst_i(h_inst),
    .imem_req_o(h_imem_req), .imem_ack_i(h_imem_ack),
    .dmem_req_o(h_dmem_req), .dmem_ack_i(h_dmem_ack),
    .BrEq_i(h_zero), .BrLt_i(h_zero),
    .PCWEn_o(h_pcwen), .IRWEn_o(h_irwen), .PCSel_o(h_pcsel), .ImmSel_o(h_immsel),
    .BrUn_o(h_brun), .ASel_o(h_asel), .BSel_o(h_bsel), .ALUSel_o(h_alusel),
    .MemRW_o(h_memrw), .RegWEn_o(h_regwen), .WBSel_o(h_wbsel),
    .retire_o(h_retire), .trap_o(h_trap), .trap_cause_o(h_cause), .state_o(h_state)
  );

  exp_t act;
  assign act = {o_state, o_imem_req, o_dmem_req, o_pcwen, o_irwen, o_pcsel, o_immsel,
                o_brun, o_asel, o_bsel, o_alusel, o_memrw, o_regwen, o_wbsel,
                o_retire, o_trap, o_cause};

  int    checks = 0;
  int    failures = 0;
  int    exp_retires = 0;
  int    dut_retires = 0;
  exp_t  exp_cur = '0;
  logic  exp_vld = 1'b0;
  string cur_nm = "";

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8];
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (alt && f3 == 3'd0) return ALU_SUB;
    if (alt && f3 == 3'd5) return ALU_SRA;
    return tbl[f3];
  endfunction

  function automatic info_t ref_info(input logic [31:0] ins, input bit csr_en);
    info_t      r;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    r = '0;
    r.f3 = f3;
    r.cls = K_ILL;
    case (ins[6:0])
      7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
        r.cls = K_ALU; r.alu = ref_alu(f3, f7[5]);
      end
      7'h13: if (f3 == 1 ? f7 == 0 : (f3 == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1)) begin
        r.cls = K_ALU; r.alu = ref_alu(f3, f3 == 5 && f7[5]); r.bsel = 1; r.imm = IMM_I;
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        r.cls = K_LD; r.bsel = 1; r.imm = IMM_I; r.wb = WB_MEM;
      end
      7'h23: if (f3 <= 2) begin
        r.cls = K_ST; r.bsel = 1; r.imm = IMM_S; r.memrw = 1;
      end
      7'h63: if (f3 != 2 && f3 != 3) begin
        r.cls = K_BR; r.imm = IMM_B; r.asel = 1; r.bsel = 1; r.brun = f3[1];
      end
      7'h37: begin r.cls = K_ALU; r.imm = IMM_U; r.bsel = 1; r.alu = ALU_PASSB; end
      7'h17: begin r.cls = K_ALU; r.imm = IMM_U; r.asel = 1; r.bsel = 1; end
      7'h6F: begin r.cls = K_JMP; r.imm = IMM_J; r.asel = 1; r.bsel = 1; r.wb = WB_PC4; end
      7'h67: if (f3 == 0) begin
        r.cls = K_JMP; r.imm = IMM_I; r.bsel = 1; r.wb = WB_PC4;
      end
      7'h0F: if (f3 <= 1) r.cls = K_FEN;
      7'h73: begin
        if (f3 == 0 && ins[19:7] == 0 && (ins[31:20] == 0 || ins[31:20] == 1)) r.cls = K_ECALL;
        else if (csr_en && f3 != 0 && f3 != 4) begin
          r.cls = K_ALU; r.imm = IMM_I; r.bsel = 1;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
    return (f3[2] ? lt : eq) ^ f3[0];
  endfunction

  function automatic exp_t e_st(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic exp_t e_cw(input logic [2:0] st, input info_t r);
    exp_t e;
    e = e_st(st);
    e.immsel = r.imm; e.brun = r.brun; e.asel = r.asel; e.bsel = r.bsel;
    e.alusel = r.alu; e.memrw = r.memrw; e.wbsel = r.wb;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_vld) begin
      checks++;
      if (o_retire) dut_retires++;
      if (act !== exp_cur) begin
        failures++;
        $display("FAIL %s t=%0t got=%h want=%h (st %0d/%0d)", cur_nm, $time, act, exp_cur,
                 o_state, exp_cur.state);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic step(input exp_t e, input string nm);
    exp_cur = e;
    cur_nm  = nm;
    exp_vld = 1'b1;
    if (e.retire) exp_retires++;
    @(posedge clk);
    #1;
  endtask

  // Random values on inputs the DUT must ignore in the current cycle.
  task automatic noise();
    imem_ack = 1'($urandom_range(0, 1));
    dmem_ack = 1'($urandom_range(0, 1));
    breq     = 1'($urandom_range(0, 1));
    brlt     = 1'($urandom_range(0, 1));
  endtask

  task automatic trap_cycle(input logic [1:0] cause);
    exp_t e;
    noise();
    e = e_st(3'd6);
    e.trap = 1; e.cause = cause; e.pcwen = 1;
    step(e, "trap");
  endtask

  // One instruction from FETCH back to FETCH. fw/mw: ack delay in cycles
  // (>= TMO means never). br: forced BrEq (-1 random). rst_at: MEM cycle to reset in.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input int br, input int rst_at);
    info_t r;
    exp_t  e;
    r = ref_info(ins, 1'b0);
    inst = ins;
    for (int k = 0; k < TMO; k++) begin
      noise();
      imem_ack = (k == fw);
      e = e_st(3'd1); e.imem_req = 1; e.irwen = (k == fw);
      step(e, "fetch");
      if (k == fw) break;
    end
    if (fw >= TMO) begin trap_cycle(2'd2); return; end
    noise();
    step(e_st(3'd2), "decode");
    if (r.cls == K_ILL)   begin trap_cycle(2'd1); return; end
    if (r.cls == K_ECALL) begin trap_cycle(2'd3); return; end
    noise();
    if (br >= 0) begin breq = br[0]; brlt = 1'b0; end
    e = e_cw(3'd3, r);
    if (r.cls == K_BR) begin
      e.pcsel = ref_taken(r.f3, breq, brlt); e.pcwen = 1; e.retire = 1;
    end else if (r.cls == K_FEN) begin
      e.pcwen = 1; e.retire = 1;
    end
    step(e, "exec");
    if (r.cls == K_BR || r.cls == K_FEN) return;
    if (r.cls == K_LD || r.cls == K_ST) begin
      for (int k = 0; k < TMO; k++) begin
        noise();
        dmem_ack = (k == mw);
        e = e_cw(3'd4, r); e.dmem_req = 1;
        if (k == rst_at) begin
          rst = 1'b1; dmem_ack = 1'b0;
          step(e, "mem_rst");
          rst = 1'b0;
          noise();
          step(e_st(3'd0), "after_rst");
          return;
        end
        if (k == mw && r.cls == K_ST) begin e.pcwen = 1; e.retire = 1; end
        step(e, "mem");
        if (k == mw) break;
      end
      if (mw >= TMO) begin trap_cycle(2'd2); return; end
      if (r.cls == K_ST) return;
    end
    noise();
    e = e_cw(3'd5, r);
    e.regwen = 1; e.pcwen = 1; e.retire = 1; e.pcsel = (r.cls == K_JMP);
    step(e, "wb");
  endtask

  function automatic int rnd_wait();
    int v;
    v = $urandom_range(0, 11);
    return (v < 6) ? 0 : v - 6;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0]  ops [12];
    logic [31:0] ins;
    int          idx;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h00};
    ins = $urandom;
    idx = $urandom_range(0, 11);
    if (idx != 11) ins[6:0] = ops[idx];
    case ($urandom_range(0, 3))
      0, 1: ins[31:25] = 7'h00;
      2:    ins[31:25] = 7'h20;
      default: ;
    endcase
    if (idx == 10 && $urandom_range(0, 1) == 1)
      ins = ($urandom_range(0, 1) == 1) ? 32'h0000_0073 : 32'h0010_0073;
    return ins;
  endfunction

  // Halting DUT: one cycle check of a reduced output vector.
  function automatic logic [9:0] hv(input logic [2:0] st, input logic req, input logic irw,
                                    input logic rw, input logic pcw, input logic tr,
                                    input logic [1:0] c);
    return {st, req, irw, rw, pcw, tr, c};
  endfunction

  task automatic hstep(input string nm, input logic [9:0] want);
    logic [9:0] got;
    @(negedge clk);
    got = {h_state, h_imem_req, h_irwen, h_regwen, h_pcwen, h_trap, h_cause};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    info_t ri;
    // Pin the model with hand-derived decodes
    ri = ref_info(32'h0020_81B3, 1'b0);
    chk("model_add_cls", int'(ri.cls), 0);
    chk("model_add_alu", int'(ri.alu), 0);
    ri = ref_info(32'h0040_A283, 1'b0);
    chk("model_lw_cls", int'(ri.cls), 1);
    chk("model_lw_wb", int'(ri.wb), 1);
    ri = ref_info(32'h0020_8463, 1'b0);
    chk("model_beq_cls", int'(ri.cls), 3);
    chk("model_beq_taken", int'(ref_taken(ri.f3, 1'b1, 1'b0)), 1);
    chk("model_zero_ill", int'(ref_info(32'h0, 1'b0).cls), 6);
    chk("model_csr_ill", int'(ref_info(32'h3401_1073, 1'b0).cls), 6);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    noise();
    step(e_st(3'd0), "reset");

    // Directed cases
    run_instr(32'h0020_81B3, 0, 0, -1, -1);  // add x3,x1,x2
    run_instr(32'h0040_A283, 0, 3, -1, -1);  // lw, ack in the expiry cycle
    run_instr(32'h0020_8463, 0, 0, 1, -1);   // beq taken
    run_instr(32'h0020_8463, 0, 0, 0, -1);   // beq not taken
    run_instr(32'h0000_0000, 0, 0, -1, -1);  // illegal
    run_instr(32'h0020_81B3, 9, 0, -1, -1);  // fetch timeout
    run_instr(32'h0040_A283, 1, 9, -1, 2);   // reset in MEM
    run_instr(32'h0011_2223, 2, 0, -1, -1);  // sw
    run_instr(32'h0000_0073, 0, 0, -1, -1);  // ecall
    run_instr(32'h0080_00EF, 0, 0, -1, -1);  // jal

    for (int n = 0; n < 300; n++)
      run_instr(rnd_inst(), rnd_wait(), rnd_wait(), -1, -1);

    exp_vld = 1'b0;
    chk("retire_count", dut_retires, exp_retires);

    // Halting DUT with CSR enabled
    h_inst = 32'h3401_1073;
    h_rst  = 1'b0;
    hstep("h_reset",  hv(3'd0, 0, 0, 0, 0, 0, 2'd0));
    h_imem_ack = 1'b1;
    hstep("h_fetch",  hv(3'd1, 1, 1, 0, 0, 0, 2'd0));
    h_imem_ack = 1'b0;
    hstep("h_decode", hv(3'd2, 0, 0, 0, 0, 0, 2'd0));
    hstep("h_exec",   hv(3'd3, 0, 0, 0, 0, 0, 2'd0));
    hstep("h_wb",     hv(3'd5, 0, 0, 1, 1, 0, 2'd0));
    for (int k = 0; k < TMO; k++)
      hstep("h_fetch_wait", hv(3'd1, 1, 0, 0, 0, 0, 2'd0));
    h_imem_ack = 1'b1;
    for (int k = 0; k < 5; k++)
      hstep("h_trap_sticky", hv(3'd6, 0, 0, 0, 0, 1, 2'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
